// File: rtl/module_key_decoder_if.sv
// -----------------------------------------------------------------------------
// module_key_decoder_if
// Keypad row-side bundle between the column scan counter / keypad and the
// key decoder.
//   col_idx   : current column index from the scan counter
//   row_in    : keypad rows, active-high, already synchronized (bit i = row i)
//   stop      : freeze request back to the scan counter
//   key_code  : last accepted key, row*4+col
//   key_valid : one-cycle pulse when key_code is updated
// master = keypad/scan side (drives col_idx, row_in)
// slave  = decoder side (drives stop, key_code, key_valid)
// -----------------------------------------------------------------------------
interface module_key_decoder_if;
    logic [1:0] col_idx;
    logic [3:0] row_in;
    logic       stop;
    logic [3:0] key_code;
    logic       key_valid;

    modport master (
        output col_idx,
        output row_in,
        input  stop,
        input  key_code,
        input  key_valid
    );

    modport slave (
        input  col_idx,
        input  row_in,
        output stop,
        output key_code,
        output key_valid
    );
endinterface

// File: rtl/module_key_decoder.sv
// -----------------------------------------------------------------------------
// module_key_decoder
// Samples the keypad rows against the current scan column, freezes the scan
// counter while a key is held, debounces press and release, and emits a
// one-cycle key_valid pulse with the key code {enc(row), col}.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset
//   kif : keypad bundle (slave side): col_idx, row_in in; stop, key_code,
//         key_valid out
// Parameter:
//   DB_CYCLES : consecutive stable cycles needed to accept a press and a
//               release (1..255)
// -----------------------------------------------------------------------------
module module_key_decoder #(
    parameter int DB_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    module_key_decoder_if.slave  kif
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] db_cnt_q,    db_cnt_d;
    logic [3:0]       row_lat_q,   row_lat_d;
    logic [1:0]       col_lat_q,   col_lat_d;
    logic [3:0]       key_code_q,  key_code_d;
    logic             key_valid_q, key_valid_d;

    logic             row_one_hot;
    logic             row_zero;

    // Row index of a one-hot row pattern.
    function automatic logic [1:0] enc(input logic [3:0] row);
        logic [1:0] idx;
        idx = 2'd0;
        case (row)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Counter never wraps; it sticks at its all-ones value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign row_zero    = (kif.row_in == 4'b0000);
    assign row_one_hot = $onehot(kif.row_in);

    // Mealy stop: the counter must hold on the very edge a press is first
    // seen, so the column captured in SCAN is still the one being driven.
    assign kif.stop = !rst && ((state_q != SCAN) || row_one_hot);

    assign kif.key_code  = key_code_q;
    assign kif.key_valid = key_valid_q;

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        row_lat_d   = row_lat_q;
        col_lat_d   = col_lat_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;

        case (state_q)
            SCAN: begin
                // Multiple rows pressed together are ignored outright.
                if (row_one_hot) begin
                    row_lat_d = kif.row_in;
                    col_lat_d = kif.col_idx;
                    db_cnt_d  = '0;
                    state_d   = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (kif.row_in == row_lat_q) begin
                    if (db_cnt_q == CNT_LAST) begin
                        key_code_d  = {enc(row_lat_q), col_lat_q};
                        key_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        db_cnt_d = sat_inc(db_cnt_q);
                    end
                end else begin
                    state_d = SCAN;
                end
            end
            HOLD: begin
                // Pattern changes while held are ignored; only a full
                // release moves on.
                if (row_zero) begin
                    db_cnt_d = '0;
                    state_d  = RELEASE;
                end
            end
            RELEASE: begin
                if (row_zero) begin
                    if (db_cnt_q == CNT_LAST) begin
                        state_d = SCAN;
                    end else begin
                        db_cnt_d = sat_inc(db_cnt_q);
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN;
            db_cnt_q    <= '0;
            row_lat_q   <= 4'd0;
            col_lat_q   <= 2'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            row_lat_q   <= row_lat_d;
            col_lat_q   <= col_lat_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

endmodule
